// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM link: receiver FSM states and default frame width.
package tdm_pkg;

    // Receiver sequencing states
    typedef enum logic {
        HUNT = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Default number of slots (bits) per frame
    localparam int unsigned DEFAULT_WIDTH = 8;

endpackage

// File: rtl/slot_counter.sv
// Mod-WIDTH slot counter driving the mux select.
//   clk, rst_n : clock, async active-low reset
//   en         : advance one slot (wraps WIDTH-1 -> 0)
//   load1      : synchronous load to slot 1 (frame_start handling), wins over en
//   cnt        : current slot index (registered)
//   last_c     : combinational flag, cnt == WIDTH-1
module slot_counter
    import tdm_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    localparam int unsigned SEL_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load1,
    output logic [SEL_W-1:0] cnt,
    output logic             last_c
);

    assign last_c = (cnt == SEL_W'(WIDTH - 1));

    // Slot register: load-to-1 restarts a frame whose slot 0 is being consumed now
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load1) begin
            cnt <= SEL_W'(1);
        end else if (en) begin
            cnt <= last_c ? '0 : cnt + SEL_W'(1);
        end
    end

endmodule

// File: rtl/tdm_demux8x1.sv
// TDM demultiplexer / deserializer: receive end of the 8:1 mux link.
// Samples din once per en-qualified slot, places it at bit position sel of a
// hidden holding register and publishes the completed word on dout.
//   clk, rst_n   : clock, async active-low reset
//   en           : slot strobe
//   frame_start  : marks the current en-qualified bit as slot 0
//   din          : serial bit from the mux
//   sel          : slot index of the next bit to be sampled (drives mux SEL)
//   dout         : last complete word, bit k = slot k
//   dout_valid   : one-cycle pulse when dout updates
//   frame_err    : one-cycle pulse when frame_start arrives mid-frame
//   locked       : high while in RUN
module tdm_demux8x1
    import tdm_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    localparam int unsigned SEL_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             frame_start,
    input  logic             din,
    output logic [SEL_W-1:0] sel,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             frame_err,
    output logic             locked
);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] hold_q;
    logic [WIDTH-1:0] hold_d;
    logic [WIDTH-1:0] dout_d;
    logic             dout_valid_d;
    logic             frame_err_d;
    logic             locked_d;
    logic             cnt_en_c;
    logic             cnt_load_c;
    logic             last_c;

    // Slot sequencing
    slot_counter #(
        .WIDTH (WIDTH)
    ) u_slot_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (cnt_en_c),
        .load1  (cnt_load_c),
        .cnt    (sel),
        .last_c (last_c)
    );

    // State, holding register and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= HUNT;
            hold_q     <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            frame_err  <= 1'b0;
            locked     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            dout       <= dout_d;
            dout_valid <= dout_valid_d;
            frame_err  <= frame_err_d;
            locked     <= locked_d;
        end
    end

    // Next-state, slot routing and output decode
    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        dout_d       = dout;
        dout_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        cnt_en_c     = 1'b0;
        cnt_load_c   = 1'b0;

        unique case (state_q)
            HUNT: begin
                // Ignore traffic until a framed slot 0 is seen
                if (en && frame_start) begin
                    hold_d     = '0;
                    hold_d[0]  = din;
                    cnt_load_c = 1'b1;
                    state_d    = RUN;
                end
            end
            RUN: begin
                if (en) begin
                    if (frame_start && (sel != '0)) begin
                        // Misaligned restart: drop the partial frame, this bit is slot 0
                        frame_err_d = 1'b1;
                        hold_d      = '0;
                        hold_d[0]   = din;
                        cnt_load_c  = 1'b1;
                    end else begin
                        hold_d[sel] = din;
                        cnt_en_c    = 1'b1;
                        if (last_c) begin
                            // Final slot bypasses hold so dout is complete on this edge
                            dout_d       = {din, hold_q[WIDTH-2:0]};
                            dout_valid_d = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = HUNT;
            end
        endcase

        locked_d = (state_d == RUN);
    end

endmodule

// File: tb/tb_tdm_demux8x1.sv
module tb_tdm_demux8x1;

    localparam int W = 8;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       frame_start;
    logic       din;
    logic [2:0] sel;
    logic [7:0] dout;
    logic       dout_valid;
    logic       frame_err;
    logic       locked;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int valid_cycs[$];

    // Reference model: bits collected since the last frame boundary
    bit         m_locked;
    bit         fq[$];
    logic [7:0] m_dout;
    bit         m_valid;
    bit         m_err;

    typedef struct {
        bit         en;
        bit         fs;
        bit         din;
        logic [2:0] sel;
        logic [7:0] dout;
        bit         valid;
        bit         err;
        bit         lock;
    } vec_t;

    vec_t tbl[W];

    tdm_demux8x1 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .frame_start (frame_start),
        .din         (din),
        .sel         (sel),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .frame_err   (frame_err),
        .locked      (locked)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at cycle %0d", name, got, exp, cyc);
        end
    endtask

    function automatic void model_reset();
        m_locked = 1'b0;
        fq.delete();
        m_dout  = '0;
        m_valid = 1'b0;
        m_err   = 1'b0;
    endfunction

    function automatic void model_step(input bit e, input bit f, input bit d);
        m_valid = 1'b0;
        m_err   = 1'b0;
        if (!e) return;
        if (!m_locked) begin
            if (f) begin
                m_locked = 1'b1;
                fq.delete();
                fq.push_back(d);
            end
            return;
        end
        if (f && fq.size() != 0) begin
            m_err = 1'b1;
            fq.delete();
            fq.push_back(d);
            return;
        end
        fq.push_back(d);
        if (fq.size() == W) begin
            m_dout = '0;
            for (int k = 0; k < W; k++) m_dout[k] = fq[k];
            m_valid = 1'b1;
            fq.delete();
        end
    endfunction

    // One clock with given inputs, then compare every output with the model
    task automatic step(input bit e, input bit f, input bit d);
        en = e;
        frame_start = f;
        din = d;
        @(posedge clk);
        #1;
        cyc++;
        model_step(e, f, d);
        chk("sel",        32'(sel),        32'(fq.size()));
        chk("dout",       32'(dout),       32'(m_dout));
        chk("dout_valid", 32'(dout_valid), 32'(m_valid));
        chk("frame_err",  32'(frame_err),  32'(m_err));
        chk("locked",     32'(locked),     32'(m_locked));
        if (dout_valid) valid_cycs.push_back(cyc);
    endtask

    task automatic send_word(input logic [7:0] w, input bit fs_first);
        for (int k = 0; k < W; k++) step(1'b1, fs_first && (k == 0), w[k]);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before the next edge
    task automatic async_reset();
        en = 1'b0;
        frame_start = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_sel",    32'(sel),        32'd0);
        chk("rst_dout",   32'(dout),       32'd0);
        chk("rst_locked", 32'(locked),     32'd0);
        chk("rst_valid",  32'(dout_valid), 32'd0);
        chk("rst_err",    32'(frame_err),  32'd0);
        #3 rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] w;
        int         sel_before;

        rst_n = 1'b0;
        en = 1'b0;
        frame_start = 1'b0;
        din = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("init_sel",    32'(sel),        32'd0);
        chk("init_dout",   32'(dout),       32'd0);
        chk("init_valid",  32'(dout_valid), 32'd0);
        chk("init_err",    32'(frame_err),  32'd0);
        chk("init_locked", 32'(locked),     32'd0);
        rst_n = 1'b1;

        // Unframed bits are ignored
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'($urandom));
        chk("hunt_sel",    32'(sel),    32'd0);
        chk("hunt_locked", 32'(locked), 32'd0);

        // Table-driven first frame 8'hA5, LSB first
        w = 8'hA5;
        for (int i = 0; i < W; i++) begin
            tbl[i] = '{en: 1'b1, fs: (i == 0), din: w[i], sel: 3'((i + 1) % W),
                       dout: (i == W - 1) ? 8'hA5 : 8'h00, valid: (i == W - 1),
                       err: 1'b0, lock: 1'b1};
        end
        for (int i = 0; i < W; i++) begin
            step(tbl[i].en, tbl[i].fs, tbl[i].din);
            chk("tbl_sel",    32'(sel),        32'(tbl[i].sel));
            chk("tbl_dout",   32'(dout),       32'(tbl[i].dout));
            chk("tbl_valid",  32'(dout_valid), 32'(tbl[i].valid));
            chk("tbl_err",    32'(frame_err),  32'(tbl[i].err));
            chk("tbl_locked", 32'(locked),     32'(tbl[i].lock));
        end

        // Back-to-back frames, framed only once
        valid_cycs.delete();
        send_word(8'h3C, 1'b1);
        chk("b2b_first", 32'(dout), 32'h3C);
        send_word(8'hFF, 1'b0);
        chk("b2b_second", 32'(dout), 32'hFF);
        chk("b2b_count", 32'(valid_cycs.size()), 32'd2);
        if (valid_cycs.size() == 2)
            chk("b2b_spacing", 32'(valid_cycs[1] - valid_cycs[0]), 32'd8);

        // Misaligned frame_start at slot 4
        step(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
        chk("abort_sel_before", 32'(sel), 32'd4);
        w = 8'h81;
        valid_cycs.delete();
        step(1'b1, 1'b1, w[0]);
        chk("abort_err",   32'(frame_err),  32'd1);
        chk("abort_valid", 32'(dout_valid), 32'd0);
        chk("abort_sel",   32'(sel),        32'd1);
        chk("abort_dout",  32'(dout),       32'hFF);
        for (int k = 1; k < W; k++) step(1'b1, 1'b0, w[k]);
        chk("abort_word",  32'(dout),       32'h81);
        chk("abort_count", 32'(valid_cycs.size()), 32'd1);

        // Gapped strobe: sel holds while en=0
        w = 8'h5A;
        for (int k = 0; k < W; k++) begin
            step(1'b1, k == 0, w[k]);
            sel_before = int'(sel);
            step(1'b0, 1'($urandom), 1'($urandom));
            chk("gap_sel_hold", 32'(sel), 32'(sel_before));
        end
        chk("gap_word", 32'(dout), 32'h5A);

        // Reset in the middle of a frame, then decode again
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1);
        chk("midrst_sel_before", 32'(sel), 32'd5);
        async_reset();
        send_word(8'h01, 1'b1);
        chk("post_rst_word",   32'(dout),   32'h01);
        chk("post_rst_locked", 32'(locked), 32'd1);

        // Randomised traffic against the model
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0), 1'($urandom));
        end

        en = 1'b0;
        frame_start = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tdm_demux8x1.md
# tdm_demux8x1

Time-division demultiplexer/deserializer. It is the receive end of the 8:1 mux datapath. The mux emits I[SEL] serially while SEL sweeps 0..7; this block samples that serial bit per slot, routes it to bit position SEL of a holding register, and presents the reassembled 8-bit word with a one-cycle valid pulse. It sits directly downstream of the mux output and owns slot sequencing (sel) for the link.

## Interface
- WIDTH, 8, number of slots/bits per frame; power of two, ≥2
- SEL_W, $clog2(WIDTH), slot index width (derived, not overridden)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  slot strobe; din is sampled and the slot advances only when en=1
- frame_start  in  1  marks the current en-qualified bit as slot 0
- din  in  1  serial bit (mux output Y)
- sel  out  SEL_W  slot index of the next bit to be sampled (drives mux SEL)
- dout  out  WIDTH  last complete word; bit k = bit received in slot k
- dout_valid  out  1  one-cycle pulse when dout updates
- frame_err  out  1  one-cycle pulse on frame_start arriving mid-frame
- locked  out  1  high in RUN state

## Operation
- Reset values: sel=0, dout=0, dout_valid=0, frame_err=0, locked=0, holding register=0, state=HUNT.
- States:
  - HUNT: en bits without frame_start are ignored and sel stays 0. en&frame_start stores din in slot 0, sets sel=1, and moves to RUN.
  - RUN: each en stores din into hold[sel], then sel increments mod WIDTH.
- Frame completion: en at sel=WIDTH-1 loads dout <= {din, hold[WIDTH-2:0]} and pulses dout_valid. sel wraps to 0. Back-to-back frames need no further frame_start.
- frame_start in RUN:
  - At sel=0: normal, no error.
  - At sel≠0: pulse frame_err, discard the partial frame (hold cleared), store din as slot 0, set sel=1. dout is not updated.
- frame_start with en=0 is ignored in both states.
- The holding register is not visible; dout changes only on frame completion.
- No HUNT re-entry except by reset.

## Timing
- All state changes happen on the rising clk edge. Outputs are registered.
- Latency: dout/dout_valid assert in the cycle after the edge that samples slot WIDTH-1.
- dout_valid and frame_err are exactly one cycle wide. They are never asserted together.
- sel is valid throughout the cycle. The upstream mux must present I[sel] before the next en edge.
- en may be held high continuously, giving one word per WIDTH cycles, or gapped arbitrarily. Gaps hold sel and hold.
- Async reset mid-frame: all outputs drop to reset values immediately. Any partial frame is lost. The block resumes in HUNT after rst_n deasserts.

## Structure
- Shared package tdm_pkg:
  - state enum {HUNT, RUN}
  - default WIDTH constant
- Sub-module slot_counter:
  - SEL_W-bit mod-WIDTH counter with en, sync load-to-1 (used on frame_start), and a terminal flag at WIDTH-1.
- Top holds the FSM, the holding register, and the output registers.

## Test plan
- Reset, then frame_start with bits of 8'hA5 LSB first (slot0=1, slot1=0, …), en=1 continuously -> dout=8'hA5, dout_valid one cycle after 8th bit, locked=1, sel back to 0.
- Two back-to-back frames 8'h3C then 8'hFF, frame_start only on the first -> two dout_valid pulses exactly 8 cycles apart, dout=8'h3C then 8'hFF.
- Bits with en=1 but no frame_start after reset -> sel stays 0, no dout_valid, locked=0.
- frame_start at slot 4 of a frame, then 8 bits of 8'h81 -> frame_err pulse at restart, no valid for the aborted frame, then dout=8'h81.
- en toggled 1/0 every cycle while sending 8'h5A -> dout=8'h5A after 16 cycles; sel holds during en=0.
- rst_n pulsed low at slot 5 -> dout=0, sel=0, locked=0 immediately; the next framed 8'h01 decodes correctly.
